// File: rtl/gridworld_episode_sequencer_if.sv
// Update-transaction bus between the episode sequencer and the Q-learning update unit.
// Latency: n/a (wires only).
// Backpressure: the master holds the transaction fields until the slave pulses upd_done.
interface gridworld_episode_sequencer_if #(
    parameter int ROW_W         = 3,
    parameter int COL_W         = 3,
    parameter int Q_VALUE_WIDTH = 16
);
    logic                            upd_start;
    logic        [ROW_W-1:0]         cur_row;
    logic        [COL_W-1:0]         cur_col;
    logic        [1:0]               action;
    logic signed [Q_VALUE_WIDTH-1:0] reward;
    logic        [ROW_W-1:0]         next_row;
    logic        [COL_W-1:0]         next_col;
    logic                            upd_done;

    modport master (
        output upd_start, cur_row, cur_col, action, reward, next_row, next_col,
        input  upd_done
    );

    modport slave (
        input  upd_start, cur_row, cur_col, action, reward, next_row, next_col,
        output upd_done
    );
endinterface

// File: rtl/gridworld_episode_sequencer.sv
// Runs random-walk Q-learning episodes on a gridworld, issuing one update per step.
// Latency: go -> first upd_start 2 cycles; upd_done -> next upd_start 3 cycles.
// Backpressure: each step stalls in WAIT until the update unit returns upd_done.
module gridworld_episode_sequencer #(
    parameter int          GRID_ROWS     = 5,
    parameter int          GRID_COLS     = 5,
    parameter int          NUM_ACTIONS   = 4,
    parameter int          Q_VALUE_WIDTH = 16,
    parameter int          START_ROW     = 0,
    parameter int          START_COL     = 0,
    parameter int          GOAL_ROW      = 4,
    parameter int          GOAL_COL      = 4,
    parameter int          MAX_STEPS     = 64,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          STEP_REWARD   = -256,
    parameter int          WALL_REWARD   = -512,
    parameter int          GOAL_REWARD   = 2560
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 go,
    input  logic [15:0]                          num_episodes,
    gridworld_episode_sequencer_if.master        upd,
    output logic                                 busy,
    output logic                                 episode_done,
    output logic                                 all_done,
    output logic [15:0]                          episode_count,
    output logic [15:0]                          step_count
);
    localparam int ROW_W = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int COL_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int ACT_W = $clog2(NUM_ACTIONS);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(GRID_ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(GRID_COLS - 1);
    localparam logic [ROW_W-1:0] START_R = ROW_W'(START_ROW);
    localparam logic [COL_W-1:0] START_C = COL_W'(START_COL);
    localparam logic [ROW_W-1:0] GOAL_R  = ROW_W'(GOAL_ROW);
    localparam logic [COL_W-1:0] GOAL_C  = COL_W'(GOAL_COL);
    localparam logic [15:0]      MAX_S   = 16'(MAX_STEPS);

    localparam logic signed [Q_VALUE_WIDTH-1:0] R_STEP = Q_VALUE_WIDTH'(STEP_REWARD);
    localparam logic signed [Q_VALUE_WIDTH-1:0] R_WALL = Q_VALUE_WIDTH'(WALL_REWARD);
    localparam logic signed [Q_VALUE_WIDTH-1:0] R_GOAL = Q_VALUE_WIDTH'(GOAL_REWARD);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_ADVANCE, S_DONE
    } state_t;

    state_t                            state;
    logic        [15:0]                lfsr;
    logic        [15:0]                num_eps;
    logic        [ROW_W-1:0]           pos_row, tgt_row;
    logic        [COL_W-1:0]           pos_col, tgt_col;
    logic signed [Q_VALUE_WIDTH-1:0]   tgt_reward;
    logic                              wall;
    logic                              ep_end;
    logic                              last_ep;

    // A move into the boundary leaves the agent where it is.
    always_comb begin
        tgt_row = pos_row;
        tgt_col = pos_col;
        wall    = 1'b0;
        case (lfsr[ACT_W-1:0])
            2'd0:    if (pos_row == '0)     wall = 1'b1; else tgt_row = pos_row - ROW_W'(1);
            2'd1:    if (pos_row == ROW_MAX) wall = 1'b1; else tgt_row = pos_row + ROW_W'(1);
            2'd2:    if (pos_col == '0)     wall = 1'b1; else tgt_col = pos_col - COL_W'(1);
            default: if (pos_col == COL_MAX) wall = 1'b1; else tgt_col = pos_col + COL_W'(1);
        endcase
        if (wall)                                        tgt_reward = R_WALL;
        else if (tgt_row == GOAL_R && tgt_col == GOAL_C) tgt_reward = R_GOAL;
        else                                             tgt_reward = R_STEP;
    end

    assign ep_end  = (upd.next_row == GOAL_R && upd.next_col == GOAL_C) ||
                     (step_count + 16'd1 == MAX_S);
    assign last_ep = (episode_count + 16'd1 == num_eps);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            lfsr          <= LFSR_SEED;
            num_eps       <= '0;
            pos_row       <= '0;
            pos_col       <= '0;
            busy          <= 1'b0;
            episode_done  <= 1'b0;
            all_done      <= 1'b0;
            episode_count <= '0;
            step_count    <= '0;
            upd.upd_start <= 1'b0;
            upd.cur_row   <= '0;
            upd.cur_col   <= '0;
            upd.action    <= '0;
            upd.reward    <= '0;
            upd.next_row  <= '0;
            upd.next_col  <= '0;
        end else begin
            upd.upd_start <= 1'b0;
            episode_done  <= 1'b0;
            all_done      <= 1'b0;
            case (state)
                S_IDLE: if (go) begin
                    num_eps       <= num_episodes;
                    pos_row       <= START_R;
                    pos_col       <= START_C;
                    step_count    <= '0;
                    episode_count <= '0;
                    busy          <= 1'b1;
                    if (num_episodes == 16'd0) begin
                        all_done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    upd.cur_row   <= pos_row;
                    upd.cur_col   <= pos_col;
                    upd.action    <= lfsr[ACT_W-1:0];
                    upd.reward    <= tgt_reward;
                    upd.next_row  <= tgt_row;
                    upd.next_col  <= tgt_col;
                    lfsr          <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
                    upd.upd_start <= 1'b1;
                    state         <= S_ISSUE;
                end
                S_ISSUE: state <= S_WAIT;
                // episode_done is raised here so it lines up with the ADVANCE cycle.
                S_WAIT: if (upd.upd_done) begin
                    episode_done <= ep_end;
                    state        <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (ep_end) begin
                        episode_count <= episode_count + 16'd1;
                        step_count    <= '0;
                        pos_row       <= START_R;
                        pos_col       <= START_C;
                        if (last_ep) begin
                            all_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            state <= S_SELECT;
                        end
                    end else begin
                        step_count <= step_count + 16'd1;
                        pos_row    <= upd.next_row;
                        pos_col    <= upd.next_col;
                        state      <= S_SELECT;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
